// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable word length, parity, stop bits and baud divisor
module uart_tx_param #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int WRITE_EDGE = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_write,
  input  logic [DATA_BITS-1:0]          i_write_data,
  output logic                          o_write_data_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  output logic                          o_interface_idle,
  output logic                          o_tx
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head, shift_q, shift_d;
  logic [ADDR_W-1:0] wp_q, rp_q;
  logic [ADDR_W:0] cnt_q;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0] idx_q, idx_d;
  logic write_q, ov_q, tx_q, tx_d, par_q, par_d, push, full, store, pop, bit_end;
  assign head    = mem_q[rp_q];
  assign push    = (WRITE_EDGE != 0) ? i_write & ~write_q : i_write;
  assign full    = cnt_q == (ADDR_W+1)'(FIFO_DEPTH);
  assign store   = push & ~full;
  assign bit_end = baud_q == CNT_W'(CLK_DIV-1);
  assign o_write_data_full = full;
  assign o_fifo_count      = cnt_q;
  assign o_overflow        = ov_q;
  assign o_interface_idle  = state_q == IDLE && cnt_q == '0;
  assign o_tx              = tx_q;
  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge i_clk)
    if (store) mem_q[wp_q] <= i_write_data;
  // FIFO pointers, occupancy, write-edge history and overflow pulse
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      write_q <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      write_q <= i_write;
      wp_q    <= wp_q + ADDR_W'(store);
      rp_q    <= rp_q + ADDR_W'(pop);
      cnt_q   <= cnt_q + (ADDR_W+1)'(store) - (ADDR_W+1)'(pop);
      ov_q    <= push & full;
    end
  // Transmit FSM state, baud timing, shifter and the registered serial line
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  // Next-state logic; a pop reloads the shifter so back-to-back frames have no gap
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + CNT_W'(1);
    tx_d    = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PAR ? par_q ^ (PARITY == 1) : 1'b1;
    case (state_q)
      IDLE:  pop = cnt_q != '0;
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA:  if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q == 4'(DATA_BITS-1) ? '0 : idx_q + 4'd1;
        if (idx_q == 4'(DATA_BITS-1)) state_d = PARITY != 0 ? PAR : STOP;
      end
      PAR:   if (bit_end) state_d = STOP;
      STOP:  if (bit_end) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(STOP_BITS-1)) begin
          state_d = IDLE;
          pop     = cnt_q != '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      shift_d = head;
      par_d   = ^head;
      idx_d   = '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four differently configured transmitters checked every cycle against a queue-based frame model
module tb_uart_tx_param;
  localparam int NC  = 4;
  localparam int DIV = 4;
  function automatic int c_par(int i);   return i == 1 ? 2 : i == 2 ? 1 : 0; endfunction
  function automatic int c_stop(int i);  return i == 2 ? 2 : 1; endfunction
  function automatic int c_depth(int i); return i == 3 ? 4 : 16; endfunction
  function automatic int c_we(int i);    return i == 3 ? 0 : 1; endfunction
  logic clk = 1'b0;
  logic rst_n;
  logic wr [NC];
  logic [7:0] wd [NC];
  logic a_tx [NC], a_full [NC], a_ov [NC], a_idle [NC];
  logic [4:0] a_cnt [NC];
  logic [7:0] q [NC][$];
  bit sw [NC][$];
  logic prev [NC], e_tx [NC], e_ov [NC];
  int n_pass = 0, n_chk = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : u
    logic [$clog2(c_depth(g)):0] cnt;
    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(c_par(g)), .STOP_BITS(c_stop(g)),
                    .FIFO_DEPTH(c_depth(g)), .WRITE_EDGE(c_we(g))) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_write(wr[g]), .i_write_data(wd[g]),
      .o_write_data_full(a_full[g]), .o_fifo_count(cnt), .o_overflow(a_ov[g]),
      .o_interface_idle(a_idle[g]), .o_tx(a_tx[g]));
    assign a_cnt[g] = 5'(cnt);
  end
  task automatic chk(int i, string n, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL u%0d %s: got %0d expected %0d at %0t", i, n, act, exp, $time);
  endtask
  // Line levels of one whole frame, each bit repeated for a full bit period
  function automatic void load(int i, logic [7:0] w);
    bit b[$];
    b.push_back(1'b0);
    for (int j = 0; j < 8; j++) b.push_back(w[j]);
    if (c_par(i) != 0) b.push_back(c_par(i) == 2 ? ^w : ~^w);
    for (int s = 0; s < c_stop(i); s++) b.push_back(1'b1);
    for (int k = 0; k < b.size(); k++)
      for (int r = 0; r < DIV; r++) sw[i].push_back(b[k]);
  endfunction
  // Advance the model by one clock edge: the line shows the previous cycle's frame level
  task automatic step(int i);
    logic push, full_pre;
    if (!rst_n) begin
      q[i].delete();
      sw[i].delete();
      prev[i] = 1'b0;
      e_tx[i] = 1'b1;
      e_ov[i] = 1'b0;
    end else begin
      push = wr[i] && (c_we(i) == 0 || !prev[i]);
      prev[i] = wr[i];
      full_pre = q[i].size() == c_depth(i);
      e_tx[i] = 1'b1;
      if (sw[i].size() > 0) e_tx[i] = sw[i].pop_front();
      if (sw[i].size() == 0 && q[i].size() > 0) load(i, q[i].pop_front());
      if (push && !full_pre) q[i].push_back(wd[i]);
      e_ov[i] = push && full_pre;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NC; i++) step(i);
    #1;
    for (int i = 0; i < NC; i++) begin
      chk(i, "tx", a_tx[i], e_tx[i]);
      chk(i, "count", a_cnt[i], q[i].size());
      chk(i, "full", a_full[i], q[i].size() == c_depth(i));
      chk(i, "overflow", a_ov[i], e_ov[i]);
      chk(i, "idle", a_idle[i], sw[i].size() == 0 && q[i].size() == 0);
    end
  endtask
  task automatic wait_idle(int i, int lim);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!a_idle[i] && n < lim);
    chk(i, "idle_wait", a_idle[i], 1);
  endtask
  initial begin
    logic [9:0] a5;
    int ovn, k;
    a5 = 10'b1_10100101_0;
    rst_n = 1'b0;
    for (int i = 0; i < NC; i++) begin
      wr[i] = 1'b0;
      wd[i] = '0;
    end
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (2) tick();
    // 8N1 frame of 0xA5 while i_write stays high for 7 edges (one push only)
    wr[0] = 1'b1;
    wd[0] = 8'hA5;
    for (int t = 0; t < 46; t++) begin
      tick();
      if (t == 0) chk(0, "edge_count_1", a_cnt[0], 1);
      if (t == 1) chk(0, "popped_count_0", a_cnt[0], 0);
      if (t >= 3 && t <= 39 && (t - 3) % 4 == 0) chk(0, "a5_bit", a_tx[0], a5[(t-3)/4]);
      if (t == 40) chk(0, "a5_idle_in_frame", a_idle[0], 0);
      if (t == 41) chk(0, "a5_idle_after", a_idle[0], 1);
      if (t == 6) wr[0] = 1'b0;
    end
    // a fresh rising edge gives a second frame
    wr[0] = 1'b1;
    wd[0] = 8'h3C;
    tick();
    chk(0, "second_push", a_cnt[0], 1);
    wait_idle(0, 100);
    wr[0] = 1'b0;
    // parity: even 0x07 -> 1, odd 0x07 -> 0; two stop bits then a queued frame starts at once
    wr[1] = 1'b1;
    wr[2] = 1'b1;
    wd[1] = 8'h07;
    wd[2] = 8'h07;
    for (int t = 0; t < 52; t++) begin
      if (t == 2) begin
        wr[1] = 1'b0;
        wr[2] = 1'b0;
      end
      if (t == 4) begin
        wr[2] = 1'b1;
        wd[2] = 8'h00;
      end
      tick();
      if (t == 39) chk(1, "even_par_07", a_tx[1], 1);
      if (t == 39) chk(2, "odd_par_07", a_tx[2], 0);
      if (t == 44) chk(1, "idle_in_stop", a_idle[1], 0);
      if (t == 45) chk(1, "idle_after_8e1", a_idle[1], 1);
      if (t >= 42 && t <= 49) chk(2, "stop2_level", a_tx[2], 1);
      if (t == 50) chk(2, "next_start", a_tx[2], 0);
    end
    wr[2] = 1'b0;
    wait_idle(2, 200);
    wr[1] = 1'b1;
    wd[1] = 8'h00;
    for (int t = 0; t < 46; t++) begin
      if (t == 2) wr[1] = 1'b0;
      tick();
      if (t == 39) chk(1, "even_par_00", a_tx[1], 0);
    end
    // overflow: six level-mode pushes into a depth-4 FIFO, sixth one dropped
    ovn = 0;
    for (int t = 0; t < 215; t++) begin
      wr[3] = t < 6;
      wd[3] = 8'(8'h10 + t);
      tick();
      if (t == 4) chk(3, "ovf_count_4", a_cnt[3], 4);
      if (t == 4) chk(3, "ovf_full", a_full[3], 1);
      if (t == 5) chk(3, "ovf_pulse", a_ov[3], 1);
      if (t == 6) chk(3, "ovf_pulse_end", a_ov[3], 0);
      if (t == 200) chk(3, "five_frames_busy", a_idle[3], 0);
      if (t == 201) chk(3, "five_frames_done", a_idle[3], 1);
      ovn += int'(a_ov[3]);
    end
    chk(3, "ovf_pulses", ovn, 1);
    // wrap-around: ten words pushed whenever there is room
    k = 0;
    ovn = 0;
    for (int t = 0; t < 2000 && (k < 10 || !a_idle[3]); t++) begin
      wr[3] = k < 10 && !a_full[3];
      wd[3] = 8'(k);
      tick();
      if (wr[3]) k++;
      ovn += int'(a_ov[3]);
    end
    wr[3] = 1'b0;
    chk(3, "wrap_words", k, 10);
    chk(3, "wrap_no_ovf", ovn, 0);
    chk(3, "wrap_idle", a_idle[3], 1);
    // asynchronous reset in the middle of a start bit with a full FIFO elsewhere
    wr[0] = 1'b1;
    wd[0] = 8'hFF;
    for (int t = 0; t < 6; t++) begin
      wr[3] = t < 5;
      wd[3] = 8'(t + 1);
      tick();
    end
    wr[3] = 1'b0;
    chk(0, "pre_reset_tx", a_tx[0], 0);
    chk(3, "pre_reset_full", a_full[3], 1);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "rst_tx", a_tx[0], 1);
    chk(0, "rst_idle", a_idle[0], 1);
    chk(3, "rst_count", a_cnt[3], 0);
    chk(3, "rst_full", a_full[3], 0);
    chk(3, "rst_overflow", a_ov[3], 0);
    chk(3, "rst_idle", a_idle[3], 1);
    wr[0] = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (50) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
